// File: rtl/fim_rdack_upsizer.sv
// Packs DATA_WIDTH words taken from an rdack-style FIFO into RATIO-word beats.
// A packet's final word (or a full accumulator) closes the beat early with out_keep marking valid slots.
module fim_rdack_upsizer #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_last,
  input  logic                        in_valid,
  output logic                        in_ack,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]            out_keep,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 pkt_cnt
);

  localparam int CW = $clog2(RATIO);

  logic [CW-1:0]               slot_reg;
  logic                        out_free;
  logic                        completes;
  logic                        load;
  logic                        store;
  logic [DATA_WIDTH*RATIO-1:0] beat_data;
  logic [RATIO-1:0]            beat_keep;

  assign out_free  = ~out_valid | out_ready;
  assign completes = in_valid & ((slot_reg == CW'(RATIO - 1)) | in_last);
  // A completing word may only be taken when the output register can be overwritten.
  assign in_ack    = in_valid & rst_n & (~completes | out_free);
  assign load      = in_ack & completes;
  assign store     = in_ack & ~completes;

  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
      assign beat_keep[gi] = (CW'(gi) <= slot_reg);

      if (gi < RATIO - 1) begin : g_acc
        logic [DATA_WIDTH-1:0] acc_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            acc_reg <= '0;
          end else if (load) begin
            acc_reg <= '0;
          end else if (store && (slot_reg == CW'(gi))) begin
            acc_reg <= in_data;
          end
        end

        assign beat_data[gi*DATA_WIDTH +: DATA_WIDTH] =
          (CW'(gi) < slot_reg)  ? acc_reg :
          (CW'(gi) == slot_reg) ? in_data : '0;
      end else begin : g_top
        // The top slot is only ever filled directly by the completing word.
        assign beat_data[gi*DATA_WIDTH +: DATA_WIDTH] =
          (CW'(gi) == slot_reg) ? in_data : '0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg <= '0;
    end else if (load) begin
      slot_reg <= '0;
    end else if (store) begin
      slot_reg <= slot_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= beat_data;
      out_keep  <= beat_keep;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (out_valid && out_ready && out_last) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fim_rdack_upsizer.sv
// Directed bench for fim_rdack_upsizer (8-bit words, 4 per beat) with a scoreboard
// queue of expected beats consumed by an independent output monitor.
module tb_fim_rdack_upsizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ack;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] pkt_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    quiet = 1'b0;

  fim_rdack_upsizer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ack   (in_ack),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Called just after a posedge; returns with the word taken and in_valid low.
  task automatic send(input logic [7:0] d, input logic l, output int waits);
    waits    = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ack && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ack) chk("ack_timeout", 32'(in_ack), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Output monitor: one comparison set per accepted beat.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_data, 32'hXXXXXXXX);
        end else begin
          b = exp_q.pop_front();
          if (!quiet)
            $display("beat data=%h keep=%h last=%0d (want %h/%h/%0d)",
                     out_data, out_keep, out_last, b.data, b.keep, b.last);
          chk("beat_data", out_data, b.data);
          chk("beat_keep", 32'(out_keep), 32'(b.keep));
          chk("beat_last", 32'(out_last), 32'(b.last));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int wsum;

    // Reset state, with a word already offered.
    in_data  = 8'h11;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_keep", 32'(out_keep), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_in_ack", 32'(in_ack), 32'd0);

    // Full beat; first ack on the first edge after release.
    expect_beat(32'h44332211, 4'hF, 1'b1);
    rst_n = 1'b1;
    #1;
    chk("first_ack", 32'(in_ack), 32'd1);
    @(posedge clk);
    #1;
    wsum = 0;
    send(8'h22, 1'b0, w); wsum += w;
    send(8'h33, 1'b0, w); wsum += w;
    send(8'h44, 1'b1, w); wsum += w;
    chk("full_throughput_waits", 32'(wsum), 32'd0);
    chk("full_latency_valid", 32'(out_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("full_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Short packet.
    expect_beat(32'h0000A2A1, 4'h3, 1'b1);
    send(8'hA1, 1'b0, w);
    send(8'hA2, 1'b1, w);
    repeat (2) @(posedge clk);
    #1;
    chk("short_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Backpressure with a pending single-word beat, then 8 streamed words.
    out_ready = 1'b0;
    expect_beat(32'h000000B1, 4'h1, 1'b1);
    expect_beat(32'hC4C3C2C1, 4'hF, 1'b0);
    expect_beat(32'h000000C5, 4'h1, 1'b1);
    expect_beat(32'h00C8C7C6, 4'h7, 1'b1);
    send(8'hB1, 1'b1, w);
    wsum = 0;
    send(8'hC1, 1'b0, w); wsum += w;
    send(8'hC2, 1'b0, w); wsum += w;
    send(8'hC3, 1'b0, w); wsum += w;
    chk("bp_noncompleting_waits", 32'(wsum), 32'd0);
    in_data  = 8'hC4;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_ack", 32'(in_ack), 32'd0);
      chk("bp_hold_data", out_data, 32'h000000B1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ack", 32'(in_ack), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("swap_valid", 32'(out_valid), 32'd1);
    chk("swap_data", out_data, 32'hC4C3C2C1);
    chk("swap_pkt_cnt_last", 32'(pkt_cnt), 32'd3);
    send(8'hC5, 1'b1, w);
    chk("swap2_valid", 32'(out_valid), 32'd1);
    chk("swap2_data", out_data, 32'h000000C5);
    chk("swap2_pkt_cnt_nolast", 32'(pkt_cnt), 32'd3);
    send(8'hC6, 1'b0, w);
    send(8'hC7, 1'b0, w);
    send(8'hC8, 1'b1, w);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_pkt_cnt", 32'(pkt_cnt), 32'd5);

    // Reset mid-packet.
    send(8'h01, 1'b0, w);
    send(8'h02, 1'b0, w);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_out_keep", 32'(out_keep), 32'd0);
    chk("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("midrst_in_ack", 32'(in_ack), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_beat(32'h00000005, 4'h1, 1'b1);
    send(8'h05, 1'b1, w);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_after_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Counter wrap over 65536 single-word packets.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    quiet = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      expect_beat({24'd0, 8'(i)}, 4'h1, 1'b1);
      send(8'(i), 1'b1, w);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_pkt_cnt_max", 32'(pkt_cnt), 32'h0000FFFF);
    expect_beat(32'h0000005A, 4'h1, 1'b1);
    send(8'h5A, 1'b1, w);
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_pkt_cnt_zero", 32'(pkt_cnt), 32'd0);
    quiet = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fim_rdack_upsizer.md
FIM_RDACK_UPSIZER -- requirements
Module: fim_rdack_upsizer

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of one input word.
REQ-002 Parameter: RATIO, default 4, input words per output beat; legal range 2..16.
REQ-003 Derived: CW = clog2(RATIO), width of the internal word-slot counter.
REQ-004 Port: clk  input  1  single clock for all logic.
REQ-005 Port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 Port: in_data  input  DATA_WIDTH  word presented by the upstream rdack-style FIFO.
REQ-007 Port: in_last  input  1  marks the final word of a packet; travels with in_data.
REQ-008 Port: in_valid  input  1  in_data/in_last are valid.
REQ-009 Port: in_ack  output  1  combinational consume strobe; word is taken in the same cycle (drives the FIFO rdack).
REQ-010 Port: out_data  output  DATA_WIDTH*RATIO  packed beat; word slot k is bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 Port: out_keep  output  RATIO  bit k set = slot k holds a valid word.
REQ-012 Port: out_last  output  1  beat ends a packet.
REQ-013 Port: out_valid  output  1  beat valid.
REQ-014 Port: out_ready  input  1  downstream accepts the beat when out_valid & out_ready.
REQ-015 Port: pkt_cnt  output  16  count of packets delivered; wraps 0xFFFF->0.

Function
REQ-016 Internal state: accumulator (RATIO-1 slots), slot counter slot[CW-1:0] in 0..RATIO-1, and one output register (out_data/keep/last/valid).
REQ-017 out_free = ~out_valid | out_ready; completes = in_valid & (slot==RATIO-1 | in_last).
REQ-018 in_ack = in_valid & rst_n & (~completes | out_free); in_ack is never asserted with in_valid low.
REQ-019 Non-completing ack: word is stored in accumulator slot "slot"; slot increments by 1.
REQ-020 Completing ack: output register loads accumulator slots 0..slot-1 plus the current word in slot "slot"; slots above "slot" load zero; out_keep = (2^(slot+1))-1; out_last = in_last; out_valid = 1; slot returns to 0; accumulator clears.
REQ-021 Latency: a beat appears on the outputs the cycle after the ack of its completing word.
REQ-022 A beat accepted (out_valid & out_ready) with no completing ack in the same cycle clears out_valid; when both occur in the same cycle, the new beat replaces the old one and out_valid stays 1.
REQ-023 While out_valid & ~out_ready: out_data/keep/last hold stable; non-completing words continue to be acked; a completing word is held (in_ack=0) until out_free.
REQ-024 Throughput: with out_ready held 1 and in_valid held 1, in_ack = 1 every cycle.
REQ-025 in_last on the first word of a packet (slot==0) produces a single-word beat with out_keep = 1.
REQ-026 pkt_cnt increments by 1 in each cycle where out_valid & out_ready & out_last.
REQ-027 No beat is ever emitted with out_keep = 0; partial beats occur only with out_last = 1.

Reset
REQ-028 While rst_n = 0: out_valid=0, out_last=0, out_keep=0, out_data=0, pkt_cnt=0, slot=0, accumulator=0, in_ack=0.
REQ-029 Reset asserted mid-packet discards all accumulated words and any pending beat; after release, the next acked word lands in slot 0.
REQ-030 First in_ack can occur in the first clk edge after rst_n deasserts.

Verification (DATA_WIDTH=8, RATIO=4)
REQ-031 Full beat: words 0x11,0x22,0x33,0x44 (last on 0x44), out_ready=1 -> in_ack 1 for 4 cycles; next cycle out_data=0x44332211, out_keep=0xF, out_last=1; pkt_cnt=1 after accept.
REQ-032 Short packet: 0xA1,0xA2 (last on 0xA2) -> out_data=0x0000A2A1, out_keep=0x3, out_last=1.
REQ-033 Backpressure: out_ready=0 with beat pending; stream 8 words -> next 3 words acked, 4th held with in_ack=0 and out_data stable; raise out_ready -> 4th acked same cycle, new beat the next cycle, no word lost or duplicated.
REQ-034 Simultaneous accept and complete: out_valid=1, out_ready=1, completing word present -> out_valid stays 1, out_data updates to new beat, pkt_cnt increments once only if the old beat had out_last.
REQ-035 Reset mid-packet: ack 0x01,0x02, pulse rst_n low -> all outputs 0; then send 0x05 with last -> out_data=0x00000005, out_keep=0x1.
REQ-036 Wrap: deliver 65536 single-word packets -> pkt_cnt returns to 0x0000.
